// File: rtl/i2s_tx.sv
// Mono I2S transmitter: takes one offset-binary sample per frame over valid/ready and
// serialises it, sign-converted and left-aligned, onto both slots with a one-BCLK delay.
module i2s_tx #(
  parameter int unsigned IN_WIDTH   = 20,
  parameter int unsigned SLOT_WIDTH = 24,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  localparam int unsigned CntW     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned FrameLen = 2 * SLOT_WIDTH;
  localparam int unsigned PosW     = $clog2(FrameLen);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  bclk_q, bclk_d;
  logic [PosW-1:0]       pos_q, pos_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  ready_q, ready_d;
  logic                  underrun_q, underrun_d;
  logic                  full_q, full_d;
  logic [SLOT_WIDTH-1:0] hold_q, hold_d;
  logic [SLOT_WIDTH-1:0] last_q, last_d;
  logic [FrameLen-1:0]   shreg_q, shreg_d;

  logic [IN_WIDTH-1:0]   signed_in;
  logic [SLOT_WIDTH-1:0] conv_word;
  logic [SLOT_WIDTH-1:0] load_word;
  logic [PosW-1:0]       pos_next;
  logic                  terminal, fall, load, accept;

  // Flipping the MSB turns the offset-binary mixer sum into two's complement.
  assign signed_in = {~sample_in[IN_WIDTH-1], sample_in[IN_WIDTH-2:0]};

  if (SLOT_WIDTH >= IN_WIDTH) begin : g_pad
    assign conv_word = SLOT_WIDTH'(signed_in) << (SLOT_WIDTH - IN_WIDTH);
  end else begin : g_trunc
    assign conv_word = signed_in[IN_WIDTH-1 -: SLOT_WIDTH];
  end

  assign terminal  = (cnt_q == CntW'(BCLK_DIV - 1));
  assign fall      = terminal && bclk_q;
  assign pos_next  = (pos_q == PosW'(FrameLen - 1)) ? '0 : pos_q + PosW'(1);
  assign load      = fall && (pos_next == PosW'(1));
  assign accept    = sample_valid && ready_q;
  assign load_word = full_q ? hold_q : last_q;

  always_comb begin
    cnt_d   = terminal ? '0 : cnt_q + CntW'(1);
    bclk_d  = terminal ? ~bclk_q : bclk_q;
    pos_d   = pos_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    if (fall) begin
      pos_d   = pos_next;
      lrclk_d = (pos_next >= PosW'(SLOT_WIDTH));
      if (load) begin
        sdata_d = load_word[SLOT_WIDTH-1];
        shreg_d = {load_word, load_word} << 1;
        last_d  = load_word;
      end else begin
        sdata_d = shreg_q[FrameLen-1];
        shreg_d = shreg_q << 1;
      end
    end
  end

  // Ready comes back one edge after the holding register empties; a load that finds it
  // empty repeats the last word and flags an underrun.
  always_comb begin
    underrun_d = load && !full_q;
    ready_d    = accept ? 1'b0 : !full_q;
    full_d     = full_q;
    hold_d     = hold_q;
    if (accept) begin
      full_d = 1'b1;
      hold_d = conv_word;
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      bclk_q     <= 1'b0;
      pos_q      <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_q     <= '0;
      last_q     <= '0;
      shreg_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      bclk_q     <= bclk_d;
      pos_q      <= pos_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      shreg_q    <= shreg_d;
    end
  end

  assign sample_ready = ready_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: default instance plus a SLOT_WIDTH=16, BCLK_DIV=1 instance, each checked
// every cycle against a frame-level model and decoded by an I2S receiver for literal checks.
module tb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst [2];
  logic        vld [2];
  logic [19:0] din [2];
  logic        rdy [2];
  logic        bck [2];
  logic        lrc [2];
  logic        sd  [2];
  logic        und [2];

  i2s_tx u_dut0 (
    .clk(clk), .reset(rst[0]), .sample_in(din[0]), .sample_valid(vld[0]),
    .sample_ready(rdy[0]), .bclk(bck[0]), .lrclk(lrc[0]), .sdata(sd[0]), .underrun(und[0])
  );

  i2s_tx #(.IN_WIDTH(20), .SLOT_WIDTH(16), .BCLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .sample_in(din[1]), .sample_valid(vld[1]),
    .sample_ready(rdy[1]), .bclk(bck[1]), .lrclk(lrc[1]), .sdata(sd[1]), .underrun(und[1])
  );

  function automatic int sw(input int i);
    return (i == 0) ? 24 : 16;
  endfunction

  function automatic int bd(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Model state: edge count since release, per-frame transmitted word, handshake state.
  int          tm      [2];
  logic [31:0] fw      [2][64];
  bit          m_full  [2];
  bit          m_ready [2];
  bit          exp_u   [2];
  logic [19:0] m_hold  [2];
  logic [31:0] m_last  [2];

  // Receiver-side decode of the serial stream.
  logic [31:0] cap_l [2][64];
  logic [31:0] cap_r [2][64];
  int          nl    [2];
  int          nr    [2];
  int          ucnt  [2];

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0d got %0h expected %0h", name, i, tm[i], act, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [19:0] x, input int s);
    logic [31:0] v;
    v = (32'(x) + 32'h80000) & 32'hFFFFF;
    if (s >= 20) return v << (s - 20);
    return v >> (20 - s);
  endfunction

  task automatic model_reset(input int i);
    tm[i] = 0; m_full[i] = 1'b0; m_ready[i] = 1'b0; exp_u[i] = 1'b0;
    m_hold[i] = '0; m_last[i] = '0;
  endtask

  task automatic model_step(input int i);
    int s, d, t, k;
    bit load, acc;
    logic [31:0] w;
    s = sw(i); d = bd(i);
    tm[i] = tm[i] + 1; t = tm[i];
    load = (t % (2 * d) == 0) && ((t / (2 * d)) % (2 * s) == 1);
    acc = vld[i] && m_ready[i];
    exp_u[i] = 1'b0;
    if (load) begin
      k = (t / (2 * d) - 1) / (2 * s);
      if (m_full[i]) begin
        w = conv(m_hold[i], s);
        m_last[i] = w;
      end else begin
        w = m_last[i];
        exp_u[i] = 1'b1;
      end
      fw[i][k % 64] = w;
    end
    m_ready[i] = acc ? 1'b0 : !m_full[i];
    if (acc) begin
      m_full[i] = 1'b1;
      m_hold[i] = din[i];
    end else if (load) begin
      m_full[i] = 1'b0;
    end
  endtask

  task automatic compare(input int i);
    int s, d, t, f, p, j, k, b;
    logic [31:0] w;
    logic es;
    s = sw(i); d = bd(i); t = tm[i];
    f = t / (2 * d);
    p = f % (2 * s);
    es = 1'b0;
    if (f > 0) begin
      j = f - 1; k = j / (2 * s); b = j % (2 * s);
      w = fw[i][k % 64];
      es = (b < s) ? w[s-1-b] : w[2*s-1-b];
    end
    chk("ready", i, 32'(rdy[i]), 32'(m_ready[i]));
    chk("bclk", i, 32'(bck[i]), 32'((t / d) % 2));
    chk("lrclk", i, 32'(lrc[i]), 32'(p >= s));
    chk("sdata", i, 32'(sd[i]), 32'(es));
    chk("underrun", i, 32'(und[i]), 32'(exp_u[i]));
  endtask

  task automatic run_model(input int i);
    forever begin
      @(posedge clk);
      if (rst[i]) begin
        model_reset(i);
      end else begin
        model_step(i);
        #1;
        compare(i);
      end
    end
  endtask

  task automatic capture(input int i);
    logic [31:0] sh, mask;
    logic pb, pl;
    sh = '0; pb = 1'b0; pl = 1'b0;
    mask = (32'h1 << sw(i)) - 32'h1;
    forever begin
      @(posedge clk);
      #1;
      if (rst[i]) begin
        sh = '0; pb = 1'b0; pl = 1'b0; nl[i] = 0; nr[i] = 0; ucnt[i] = 0;
      end else begin
        if (und[i]) ucnt[i]++;
        if (bck[i] && !pb) begin
          sh = {sh[30:0], sd[i]};
          // The bit sampled as lrclk changes is the LSB of the previous channel's word.
          if (lrc[i] != pl) begin
            if (!pl) begin
              cap_l[i][nl[i] % 64] = sh & mask;
              nl[i]++;
            end else begin
              cap_r[i][nr[i] % 64] = sh & mask;
              nr[i]++;
            end
          end
          pl = lrc[i];
        end
        pb = bck[i];
      end
    end
  endtask

  task automatic wait_t(input int i, input int target);
    while (tm[i] < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [19:0] x);
    int n;
    @(negedge clk);
    vld[i] = 1'b1;
    din[i] = x;
    n = 0;
    while (!rdy[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      errors++;
      checks++;
      $display("FAIL send_timeout inst%0d got ready=0 expected ready=1", i);
    end else begin
      @(posedge clk);
    end
    #2;
    vld[i] = 1'b0;
  endtask

  task automatic do_reset(input int i);
    @(negedge clk);
    rst[i] = 1'b1;
    repeat (3) @(negedge clk);
    rst[i] = 1'b0;
  endtask

  task automatic run0();
    do_reset(0);
    wait_t(0, 1); chk("ready_first", 0, 32'(rdy[0]), 32'h1);
    wait_t(0, 3); chk("bclk_t3", 0, 32'(bck[0]), 32'h0);
    wait_t(0, 4); chk("bclk_rise", 0, 32'(bck[0]), 32'h1);
    wait_t(0, 8);
    chk("fall_bclk", 0, 32'(bck[0]), 32'h0);
    chk("fall_lrclk", 0, 32'(lrc[0]), 32'h0);
    chk("fall_sdata", 0, 32'(sd[0]), 32'h0);
    chk("underrun_first", 0, 32'(und[0]), 32'h1);
    wait_t(0, 9); chk("underrun_pulse", 0, 32'(und[0]), 32'h0);
    wait_t(0, 392); chk("underrun_frame1", 0, 32'(und[0]), 32'h1);
    send(0, 20'hFFFFF);
    send(0, 20'h80000);
    send(0, 20'h00000);
    send(0, 20'h12345);
    send(0, 20'h11111);
    send(0, 20'h22222);
    send(0, 20'hABCDE);
    wait_t(0, 4300);
    chk("frames_left", 0, 32'(nl[0]), 32'd11);
    chk("frames_right", 0, 32'(nr[0]), 32'd11);
    chk("l0", 0, cap_l[0][0], 32'h0);
    chk("l2_fullscale", 0, cap_l[0][2], 32'h7FFFF0);
    chk("r2_fullscale", 0, cap_r[0][2], 32'h7FFFF0);
    chk("l3_midscale", 0, cap_l[0][3], 32'h000000);
    chk("l4_zero", 0, cap_l[0][4], 32'h800000);
    chk("r4_zero", 0, cap_r[0][4], 32'h800000);
    chk("l5_order", 0, cap_l[0][5], 32'h923450);
    chk("r5_order", 0, cap_r[0][5], 32'h923450);
    chk("l6_bp", 0, cap_l[0][6], 32'h911110);
    chk("l7_bp", 0, cap_l[0][7], 32'hA22220);
    chk("r7_bp", 0, cap_r[0][7], 32'hA22220);
    chk("l8_abcde", 0, cap_l[0][8], 32'h2BCDE0);
    chk("l9_repeat", 0, cap_l[0][9], 32'h2BCDE0);
    chk("r10_repeat", 0, cap_r[0][10], 32'h2BCDE0);
    chk("underrun_count", 0, 32'(ucnt[0]), 32'd5);
    wait_t(0, 4309);
    // Frame position 10 with bclk, sdata and ready all high just before the reset.
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("rst_ready", 0, 32'(rdy[0]), 32'h0);
    chk("rst_bclk", 0, 32'(bck[0]), 32'h0);
    chk("rst_lrclk", 0, 32'(lrc[0]), 32'h0);
    chk("rst_sdata", 0, 32'(sd[0]), 32'h0);
    chk("rst_underrun", 0, 32'(und[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    wait_t(0, 8); chk("restart_underrun", 0, 32'(und[0]), 32'h1);
    wait_t(0, 400);
    chk("restart_l0", 0, cap_l[0][0], 32'h0);
    chk("restart_r0", 0, cap_r[0][0], 32'h0);
  endtask

  task automatic run1();
    do_reset(1);
    // Accepted on the very first load edge: goes to holding, that load is an underrun.
    send(1, 20'h12345);
    wait_t(1, 66); chk("p16_no_underrun", 1, 32'(und[1]), 32'h0);
    wait_t(1, 130); chk("p16_underrun_f2", 1, 32'(und[1]), 32'h1);
    wait_t(1, 200);
    chk("p16_l0", 1, cap_l[1][0], 32'h0);
    chk("p16_l1", 1, cap_l[1][1], 32'h9234);
    chk("p16_r1", 1, cap_r[1][1], 32'h9234);
    chk("p16_l2", 1, cap_l[1][2], 32'h9234);
    chk("p16_ucount", 1, 32'(ucnt[1]), 32'd3);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; din[i] = '0;
      nl[i] = 0; nr[i] = 0; ucnt[i] = 0;
    end
    model_reset(0);
    model_reset(1);
    fork
      run_model(0);
      run_model(1);
      capture(0);
      capture(1);
    join_none
    fork
      run0();
      run1();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Output-side counterpart of the 16-voice mixer: consumes the 20-bit mixed sample stream and serialises it to an external I2S audio DAC.
- Accepts one sample per audio frame through a valid/ready handshake and converts the mixer's unsigned (offset-binary) sum to two's complement.
- Generates BCLK and LRCLK and transmits the same word on the left and right slots (mono).

Parameters:
- IN_WIDTH, 20, width of mixer sample input (unsigned sum of 16 x 16-bit voices).
- SLOT_WIDTH, 24, bits per I2S channel slot; must be >= 2.
- BCLK_DIV, 4, clk cycles per BCLK half-period; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_in  input  IN_WIDTH  unsigned mixed sample from the mixer.
- sample_valid  input  1  sample_in valid this cycle.
- sample_ready  output  1  block can accept a sample this cycle.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  I2S word select; 0 = left, 1 = right.
- sdata  output  1  I2S serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame starts with no new sample.

Behaviour:
- Reset, asynchronous and active-high; all outputs are registered:
  - bclk=0, lrclk=0, sdata=0, sample_ready=0, underrun=0.
  - Divider count=0, frame position p=0, holding register empty, last word=0.
  - sample_ready rises on the first clk edge after reset deasserts.
  - Reset asserted mid-frame aborts the frame immediately; there is no partial-frame completion.
- Divider:
  - Counter runs 0..BCLK_DIV-1; at terminal count it wraps and bclk toggles.
  - BCLK period = 2*BCLK_DIV clk.
  - "Fall event" = the clk edge at which bclk goes 1->0.
  - First bclk rise occurs BCLK_DIV clk edges after reset release.
- Handshake:
  - Accept when sample_valid && sample_ready: holding <= sample_in, holding full, sample_ready <= 0 next cycle.
  - sample_ready returns to 1 on the clk edge after holding empties.
  - sample_valid while ready=0 is ignored; the sample is not queued.
- Conversion: word = {~sample_in[IN_WIDTH-1], sample_in[IN_WIDTH-2:0]}, left-aligned in SLOT_WIDTH.
  - Zero-pad LSBs if SLOT_WIDTH > IN_WIDTH.
  - Drop LSBs if SLOT_WIDTH < IN_WIDTH.
  - Midscale 2^(IN_WIDTH-1) maps to 0.
- Frame position p runs 0..2*SLOT_WIDTH-1 and advances by 1, wrapping, on each fall event. lrclk, sdata and p update on the same clk edge.
  - lrclk = 0 for p in 0..SLOT_WIDTH-1.
  - lrclk = 1 for p in SLOT_WIDTH..2*SLOT_WIDTH-1.
  - One-BCLK I2S delay: sdata at p=1..SLOT_WIDTH carries left word bits MSB..LSB.
  - sdata at p=SLOT_WIDTH+1..2*SLOT_WIDTH-1 carries right word bits MSB..bit1.
  - sdata at p=0 of the following frame carries right word bit0.
- Load, on the fall event where p becomes 1:
  - If holding is full: 2*SLOT_WIDTH shift register <= {word, word}, last word <= word, holding emptied.
  - If holding is empty: reload {last word, last word} and pulse underrun high for exactly one clk.
  - The load cycle drives the MSB onto sdata.
- Simultaneous accept and load on the same edge cannot occur while holding is full (ready=0).
  - If holding is empty and a sample is accepted on the load edge, it goes to holding and the load is an underrun. There is no bypass.
- Frame length = 4*SLOT_WIDTH*BCLK_DIV clk; 384 with defaults.

Test Plan:
1. Reset-release with no input, defaults:
   - sample_ready=1 one clk after release.
   - First bclk rise at clk 4, first fall event at clk 8 with lrclk=0, sdata=0 and underrun pulsing 1 clk.
   - Frame repeats every 384 clk with all sdata 0.
2. Full-scale and midscale conversion:
   - Send 0xFFFFF before the first load -> left and right words 0x7FFFF0.
   - Send 0x80000 in the next frame -> 0x000000.
   - Send 0x00000 in the frame after -> 0x800000.
3. Bit order and slot alignment:
   - Send 0x12345 -> both slots 0x923450.
   - Check MSB one BCLK after each lrclk edge and right-slot LSB at p=0 of the following frame.
4. Handshake back-pressure:
   - Accept 0x11111, then hold sample_valid with 0x22222 for a whole frame.
   - Required: ready=0 until the load; 0x22222 is accepted the cycle after ready returns and is transmitted next frame; no underrun.
5. Underrun repeat:
   - Send 0xABCDE, then stop.
   - The next two frames repeat 0x2BCDE0 in both slots, and underrun pulses once per frame.
6. Reset mid-frame and parameters:
   - Assert reset at p=10: outputs clear in the same cycle and the frame restarts from p=0.
   - Rerun scenario 3 with SLOT_WIDTH=16, BCLK_DIV=1: 0x12345 -> 0x9234, frame = 64 clk.
